mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RISC-V core; sits directly downstream of the EX/MEM pipeline register and consumes its MEM_* outputs.
- Runs a req/ack handshake with the data memory and aligns store data and byte strobes.
- Sign/zero-extends load data and selects the write-back result.
- Registers the result into MEM/WB outputs; raises mem_stall to freeze upstream stages while an access is outstanding.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_load_align.sv | 26 ++
 rtl/mem_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes and the access FSM states.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed byte/half out of the read word and
// sign- or zero-extends it according to funct3.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = word >> {byte_off, 3'b000};
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h000000, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0000, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V core: data-memory req/ack handshake, store lane
// alignment, load extension and the MEM/WB register. Define MEM_TIMEOUT_EN to abort stuck accesses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Memread,
    input  logic        MEM_Memwrite,
    input  logic        MEM_Memtoreg,
    input  logic        MEM_Regwrite,
    input  logic        MEM_RDsrc,
    input  logic [31:0] MEM_pc_to_reg,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_forward_rs2_data,
    input  logic [4:0]  MEM_rd_addr,
    input  logic [2:0]  MEM_funct3,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        misalign,
    output logic        WB_Regwrite,
    output logic [4:0]  WB_rd_addr,
    output logic [31:0] WB_rd_data
);

    mem_state_e  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
    logic [31:0] wb_rd_data_q, wb_rd_data_d;

    logic        memop;
    logic        is_store;
    logic        misaligned;
    logic        misalign_req;
    logic        expired;
    logic        abort;
    logic [1:0]  byte_off;
    logic [1:0]  acc_size;
    logic [31:0] load_data;
    logic [31:0] result;

    // A load and store flagged together is handled as a load.
    assign byte_off   = MEM_alu_out[1:0];
    assign acc_size   = MEM_funct3[1:0];
    assign memop      = MEM_Memread | MEM_Memwrite;
    assign is_store   = MEM_Memwrite & ~MEM_Memread;
    assign misaligned = ((acc_size == F3_H[1:0]) && byte_off[0]) ||
                        ((acc_size == F3_W[1:0]) && (byte_off != 2'b00));

    assign dm_addr = {MEM_alu_out[31:2], 2'b00};
    assign dm_we   = is_store;

    always_comb begin
        dm_wstrb = 4'b1111;
        dm_wdata = MEM_forward_rs2_data;
        case (acc_size)
            F3_B[1:0]: begin
                dm_wstrb = 4'b0001 << byte_off;
                dm_wdata = {4{MEM_forward_rs2_data[7:0]}};
            end
            F3_H[1:0]: begin
                dm_wstrb = 4'b0011 << byte_off;
                dm_wdata = {2{MEM_forward_rs2_data[15:0]}};
            end
            default: ;
        endcase
        if (!is_store) begin
            dm_wstrb = 4'b0000;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign abort   = timeout_q;

    // The counter only runs while waiting in BUSY; timeout_q marks the aborted DONE cycle.
    always_comb begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (state_q == BUSY && !dm_ack) begin
            cnt_d     = cnt_q + 1'b1;
            timeout_d = expired;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign expired = 1'b0;
    assign abort   = 1'b0;
`endif

    // Handshake FSM; all combinational controls are forced low while reset is asserted.
    always_comb begin
        state_d      = state_q;
        dm_req       = 1'b0;
        mem_stall    = 1'b0;
        misalign_req = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (memop) begin
                        if (misaligned) begin
                            misalign_req = 1'b1;
                        end else begin
                            dm_req    = 1'b1;
                            mem_stall = 1'b1;
                            state_d   = dm_ack ? DONE : BUSY;
                        end
                    end
                end
                BUSY: begin
                    dm_req    = 1'b1;
                    mem_stall = 1'b1;
                    if (dm_ack || expired) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign misalign = misalign_req | (rst & (state_q == DONE) & abort);
    assign rdata_d  = (dm_req && dm_ack) ? dm_rdata : rdata_q;

    mem_load_align u_load_align (
        .word      (rdata_q),
        .byte_off  (byte_off),
        .funct3    (MEM_funct3),
        .load_data (load_data)
    );

    always_comb begin
        result = MEM_RDsrc ? MEM_pc_to_reg : MEM_alu_out;
        if (MEM_Memtoreg) begin
            result = load_data;
        end
    end

    // A stall inserts a bubble; misaligned or aborted accesses never write rd.
    always_comb begin
        wb_regwrite_d = 1'b0;
        wb_rd_addr_d  = wb_rd_addr_q;
        wb_rd_data_d  = wb_rd_data_q;
        if (!mem_stall) begin
            wb_regwrite_d = MEM_Regwrite & ~misalign;
            wb_rd_addr_d  = MEM_rd_addr;
            wb_rd_data_d  = result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            rdata_q       <= '0;
            wb_regwrite_q <= 1'b0;
            wb_rd_addr_q  <= '0;
            wb_rd_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            rdata_q       <= rdata_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_rd_addr_q  <= wb_rd_addr_d;
            wb_rd_data_q  <= wb_rd_data_d;
        end
    end

    assign WB_Regwrite = wb_regwrite_q;
    assign WB_rd_addr  = wb_rd_addr_q;
    assign WB_rd_data  = wb_rd_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases with literal expectations plus a randomized
// instruction stream checked every cycle against a transaction-level model.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        MEM_Memread, MEM_Memwrite, MEM_Memtoreg, MEM_Regwrite, MEM_RDsrc;
    logic [31:0] MEM_pc_to_reg, MEM_alu_out, MEM_forward_rs2_data;
    logic [4:0]  MEM_rd_addr;
    logic [2:0]  MEM_funct3;
    logic        dm_req, dm_we, dm_ack, mem_stall, misalign;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic        WB_Regwrite;
    logic [4:0]  WB_rd_addr;
    logic [31:0] WB_rd_data;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .MEM_Memread(MEM_Memread), .MEM_Memwrite(MEM_Memwrite), .MEM_Memtoreg(MEM_Memtoreg),
        .MEM_Regwrite(MEM_Regwrite), .MEM_RDsrc(MEM_RDsrc), .MEM_pc_to_reg(MEM_pc_to_reg),
        .MEM_alu_out(MEM_alu_out), .MEM_forward_rs2_data(MEM_forward_rs2_data),
        .MEM_rd_addr(MEM_rd_addr), .MEM_funct3(MEM_funct3),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .misalign(misalign),
        .WB_Regwrite(WB_Regwrite), .WB_rd_addr(WB_rd_addr), .WB_rd_data(WB_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rdEn, wrEn, mtr, rw, rdSrc;
        logic [31:0] pc, alu, rs2, word;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int          lat;
    } instr_t;

    typedef struct {
        bit          stall, req, we, mis, chkWdata, wbRw, wbKnown;
        logic [31:0] addr, wdata, wbData;
        logic [3:0]  strb;
        logic [4:0]  wbAddr;
    } exp_t;

    exp_t        expq[$];
    exp_t        curExp;
    int          nChecks = 0;
    int          nPass = 0;
    int          stallCnt = 0;
    bit          sawReq = 0;
    bit          sawMis = 0;
    logic [3:0]  lastStrb = '0;
    logic [31:0] lastWdata = '0;
    logic        lastWe = 1'b0;

    bit          mRw = 0;
    logic [4:0]  mAddr = '0;
    logic [31:0] mData = '0;
    bit          mKnown = 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        else nPass++;
    endtask

    function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] s;
        s = w >> (8 * a);
        case (f3)
            3'd0:    return 32'(signed'(s[7:0]));
            3'd4:    return 32'(s[7:0]);
            3'd1:    return 32'(signed'(s[15:0]));
            3'd5:    return 32'(s[15:0]);
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] modelStrb(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] sz, input logic [31:0] v);
        if (sz == 2'd0) return 32'(v[7:0]) * 32'h01010101;
        if (sz == 2'd1) return 32'(v[15:0]) * 32'h00010001;
        return v;
    endfunction

    function automatic instr_t mkInstr(input bit rdEn, input bit wrEn, input bit mtr, input bit rw,
                                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                                       input logic [31:0] word, input logic [4:0] rd, input int lat);
        instr_t t;
        t.rdEn = rdEn; t.wrEn = wrEn; t.mtr = mtr; t.rw = rw; t.rdSrc = 1'b0;
        t.pc = 32'h0000_1000; t.alu = alu; t.rs2 = rs2; t.word = word;
        t.rd = rd; t.f3 = f3; t.lat = lat;
        return t;
    endfunction

    function automatic instr_t randInstr();
        instr_t t;
        t = mkInstr(0, 0, 0, 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    5'($urandom), $urandom_range(0, 3));
        t.pc = $urandom;
        t.rdSrc = 1'($urandom);
        case ($urandom_range(0, 3))
            1, 3: begin
                t.rdEn = 1; t.mtr = 1; t.rw = 1;
                t.wrEn = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 4))
                    0: t.f3 = 3'd0;
                    1: t.f3 = 3'd1;
                    2: t.f3 = 3'd2;
                    3: t.f3 = 3'd4;
                    default: t.f3 = 3'd5;
                endcase
            end
            2: begin
                t.wrEn = 1; t.rw = ($urandom_range(0, 3) == 0);
                t.f3 = 3'($urandom_range(0, 2));
            end
            default: ;
        endcase
        return t;
    endfunction

    task automatic applyStimulus(input instr_t t, input bit ack);
        MEM_Memread = t.rdEn; MEM_Memwrite = t.wrEn; MEM_Memtoreg = t.mtr;
        MEM_Regwrite = t.rw; MEM_RDsrc = t.rdSrc; MEM_pc_to_reg = t.pc;
        MEM_alu_out = t.alu; MEM_forward_rs2_data = t.rs2; MEM_rd_addr = t.rd;
        MEM_funct3 = t.f3;
        dm_ack = ack;
        dm_rdata = ack ? t.word : $urandom;
    endtask

    // Holds one instruction for as many cycles as its access takes; entered and left at posedge+1.
    task automatic runInstr(input instr_t t, input bit strayAck);
        bit memop, isStore, mis, access;
        logic [1:0] a, sz;
        logic [31:0] res;
        int ncyc;
        exp_t e;
        memop   = t.rdEn | t.wrEn;
        isStore = t.wrEn & ~t.rdEn;
        a       = t.alu[1:0];
        sz      = t.f3[1:0];
        mis     = memop && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0));
        access  = memop && !mis;
        ncyc    = access ? t.lat + 2 : 1;
        res     = t.mtr ? modelLoad(t.word, a, t.f3) : (t.rdSrc ? t.pc : t.alu);
        for (int c = 0; c < ncyc; c++) begin
            applyStimulus(t, (access && c == t.lat) || (!access && strayAck));
            e.stall = access && (c <= t.lat);
            e.req = e.stall;
            e.we = isStore;
            e.mis = mis;
            e.addr = t.alu & 32'hFFFF_FFFC;
            e.strb = isStore ? modelStrb(sz, a) : 4'h0;
            e.wdata = modelWdata(sz, t.rs2);
            e.chkWdata = isStore;
            e.wbRw = mRw; e.wbAddr = mAddr; e.wbData = mData; e.wbKnown = mKnown;
            expq.push_back(e);
            if (!e.stall) begin
                mRw = t.rw && !mis; mAddr = t.rd; mData = res; mKnown = !(mis && t.mtr);
            end else begin
                mRw = 0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic clearProbe();
        stallCnt = 0; sawReq = 0; sawMis = 0;
    endtask

    always @(negedge clk) begin
        if (mem_stall) stallCnt++;
        if (misalign) sawMis = 1;
        if (dm_req) begin
            sawReq = 1; lastStrb = dm_wstrb; lastWdata = dm_wdata; lastWe = dm_we;
        end
        if (expq.size() > 0) begin
            curExp = expq.pop_front();
            checkOutput("mem_stall", 32'(mem_stall), 32'(curExp.stall));
            checkOutput("dm_req", 32'(dm_req), 32'(curExp.req));
            checkOutput("misalign", 32'(misalign), 32'(curExp.mis));
            checkOutput("WB_Regwrite", 32'(WB_Regwrite), 32'(curExp.wbRw));
            checkOutput("WB_rd_addr", 32'(WB_rd_addr), 32'(curExp.wbAddr));
            if (curExp.wbKnown) checkOutput("WB_rd_data", WB_rd_data, curExp.wbData);
            if (curExp.req) begin
                checkOutput("dm_we", 32'(dm_we), 32'(curExp.we));
                checkOutput("dm_addr", dm_addr, curExp.addr);
                checkOutput("dm_wstrb", 32'(dm_wstrb), 32'(curExp.strb));
                if (curExp.chkWdata) checkOutput("dm_wdata", dm_wdata, curExp.wdata);
            end
        end
    end

    initial begin
        instr_t nop;
        nop = mkInstr(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
        rst = 1'b0;
        applyStimulus(nop, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_WB_Regwrite", 32'(WB_Regwrite), 32'd0);
        checkOutput("reset_WB_rd_addr", 32'(WB_rd_addr), 32'd0);
        checkOutput("reset_WB_rd_data", WB_rd_data, 32'd0);
        checkOutput("reset_dm_req", 32'(dm_req), 32'd0);
        checkOutput("reset_mem_stall", 32'(mem_stall), 32'd0);
        rst = 1'b1;

        clearProbe();
        runInstr(mkInstr(1, 0, 1, 1, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 2), 0);
        checkOutput("lw_stall_cycles", stallCnt, 32'd3);
        checkOutput("lw_wb_data", WB_rd_data, 32'hDEADBEEF);
        checkOutput("lw_wb_regwrite", 32'(WB_Regwrite), 32'd1);
        checkOutput("lw_wb_addr", 32'(WB_rd_addr), 32'd5);

        runInstr(mkInstr(1, 0, 1, 1, 3'd0, 32'h103, 32'h0, 32'h80112233, 5'd6, 1), 0);
        checkOutput("lb_sign", WB_rd_data, 32'hFFFFFF80);
        runInstr(mkInstr(1, 0, 1, 1, 3'd4, 32'h103, 32'h0, 32'h80112233, 5'd7, 0), 0);
        checkOutput("lbu_zero", WB_rd_data, 32'h00000080);

        clearProbe();
        runInstr(mkInstr(0, 1, 0, 0, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 5'd8, 0), 0);
        checkOutput("sh_wstrb", 32'(lastStrb), 32'hC);
        checkOutput("sh_wdata", lastWdata, 32'hABCDABCD);
        checkOutput("sh_we", 32'(lastWe), 32'd1);
        checkOutput("sh_stall_cycles", stallCnt, 32'd1);
        checkOutput("sh_no_writeback", 32'(WB_Regwrite), 32'd0);

        clearProbe();
        runInstr(mkInstr(1, 0, 1, 1, 3'd2, 32'h101, 32'h0, 32'h0, 5'd9, 0), 0);
        checkOutput("mis_no_req", 32'(sawReq), 32'd0);
        checkOutput("mis_pulse", 32'(sawMis), 32'd1);
        checkOutput("mis_no_stall", stallCnt, 32'd0);
        checkOutput("mis_no_writeback", 32'(WB_Regwrite), 32'd0);

        // Reset while the access is waiting in BUSY, then a stray ack.
        applyStimulus(mkInstr(1, 0, 1, 1, 3'd2, 32'h300, 32'h0, 32'h0, 5'd10, 0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(nop, 1);
        #1;
        checkOutput("rst_busy_dm_req", 32'(dm_req), 32'd0);
        checkOutput("rst_busy_mem_stall", 32'(mem_stall), 32'd0);
        checkOutput("rst_busy_WB_Regwrite", 32'(WB_Regwrite), 32'd0);
        checkOutput("rst_busy_WB_rd_addr", 32'(WB_rd_addr), 32'd0);
        checkOutput("rst_busy_WB_rd_data", WB_rd_data, 32'd0);
        mRw = 0; mAddr = '0; mData = '0; mKnown = 1;
        runInstr(nop, 1);
        clearProbe();
        runInstr(mkInstr(1, 0, 1, 1, 3'd5, 32'h402, 32'h0, 32'h8001_1234, 5'd11, 1), 0);
        checkOutput("after_rst_stall_cycles", stallCnt, 32'd2);
        checkOutput("after_rst_lhu", WB_rd_data, 32'h00008001);

        for (int i = 0; i < 400; i++) begin
            runInstr(randInstr(), 0);
        end
        runInstr(nop, 0);
        @(negedge clk);
        checkOutput("queue_drained", expq.size(), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
